addsub_arbiter: RTL and testbench
=================================

ADDSUB_ARBITER -- requirements
Module: addsub_arbiter

Interface
REQ-001 Parameter NREQ, default 4: number of requesters, 2..8.
REQ-002 Parameter W, default 32: operand/result width.
REQ-003 Port clk  input  1: clock.
REQ-004 Port rstN  input  1: reset; asynchronous, active-low.
REQ-005 Port req_valid  input  NREQ: per-requester operation request.
REQ-006 Port req_mode  input  NREQ: per-requester op; 0 = add, 1 = subtract.
REQ-007 Port req_a, req_b  input  NREQ*W each: packed operands; requester i occupies bits [i*W +: W].
REQ-008 Port req_ready  output  NREQ: one-hot grant/accept strobe.
REQ-009 Port dp_a, dp_b  output  W each: operands to the shared registered add/sub datapath.
REQ-010 Port dp_mode  output  1: mode to the datapath.
REQ-011 Port dp_sum  input  W: datapath registered result, valid one clock after operands are presented.
REQ-012 Port rsp_valid  output  1: response available.
REQ-013 Port rsp_ready  input  1: response consumer accepts.
REQ-014 Port rsp_id  output  clog2(NREQ): index of the requester that owns the response.
REQ-015 Port rsp_sum  output  W: result.
REQ-016 Port busy  output  1: high in any state other than IDLE.

Function
REQ-017 FSM SHALL have states IDLE, ISSUE, CAPTURE, RESP; one operation is in flight at a time.
REQ-018 IDLE: if any req_valid is set, grant one requester g per REQ-030, assert req_ready[g] combinationally for that cycle, latch req_a/req_b/req_mode[g] and g, then go to ISSUE; otherwise stay in IDLE.
REQ-019 req_ready SHALL be zero in every state except IDLE, and at most one bit SHALL be set.
REQ-020 A request is accepted only on a cycle where req_valid[i] and req_ready[i] are both high. Requesters hold operands stable while waiting.
REQ-021 dp_a, dp_b, dp_mode SHALL be driven from the latched operand registers and SHALL be stable from ISSUE through CAPTURE.
REQ-022 ISSUE: unconditionally go to CAPTURE, so the datapath registers the result at the end of ISSUE.
REQ-023 CAPTURE: latch dp_sum into rsp_sum, then go to RESP. dp_sum is ignored in all other states.
REQ-024 RESP: rsp_valid=1. rsp_id and rsp_sum are held stable until rsp_ready=1, then go to IDLE. No new grant is made in the same cycle.
REQ-025 Latency: a grant at cycle T gives rsp_valid at T+3. Throughput is at most one operation per 4 cycles with rsp_ready held high.
REQ-026 Arithmetic is the datapath's and is modulo 2^W; the block performs no overflow or underflow detection. Response data is passed through unmodified.
REQ-027 A req_valid deasserted before acceptance is a legal withdrawal; it causes no grant.

Reset
REQ-028 On rstN low, the block SHALL go to IDLE immediately and asynchronously, regardless of state. All outputs go to zero: req_ready, dp_a, dp_b, dp_mode, rsp_valid, rsp_id, rsp_sum, busy.
REQ-029 Reset mid-operation SHALL discard the in-flight operation with no response. The arbitration pointer resets to NREQ-1, so requester 0 wins first.

Configuration
REQ-030 With macro ADDSUB_ARB_RR_EN defined, arbitration SHALL be round-robin: the search starts at pointer+1 modulo NREQ, and the pointer updates to g on each grant. Without it, arbitration SHALL be fixed-priority (lowest index wins) and the pointer is absent.

Verification
REQ-031 Single request: req_valid[2]=1, a=32'd7, b=32'd5, mode=0 -> req_ready=4'b0100 for one cycle, rsp_valid 3 cycles later, rsp_sum=12, rsp_id=2.
REQ-032 Wrap: a=0, b=1, mode=1 -> rsp_sum=32'hFFFF_FFFF. Separately, a=32'hFFFF_FFFF, b=1, mode=0 -> rsp_sum=0.
REQ-033 All four requesters valid continuously, rsp_ready=1, RR_EN defined -> grants 0,1,2,3,0 at 4-cycle spacing. With RR_EN undefined -> grants 0,0,0,…
REQ-034 Backpressure: rsp_ready=0 for 10 cycles in RESP -> rsp_valid, rsp_sum, rsp_id stable, req_ready=0 throughout, and the next grant comes one cycle after rsp_ready rises.
REQ-035 Reset asserted in CAPTURE -> outputs zero immediately, no rsp_valid after release. The first grant after release goes to requester 0 when all are valid.
REQ-036 Withdrawal: req_valid[1] pulsed for one cycle while busy -> no grant to requester 1 and no response with rsp_id=1.

Source files
------------

// File: rtl/addsub_arbiter.sv
// rtl/addsub_arbiter.sv - arbitrates NREQ add/sub requesters onto one shared registered datapath (round-robin when ADDSUB_ARB_RR_EN is defined, fixed-priority otherwise)
module addsub_arbiter #(
  parameter int NREQ = 4,
  parameter int W    = 32,
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic              clk,
  input  logic              rstN,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ-1:0]   req_mode,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  output logic [NREQ-1:0]   req_ready,
  output logic [W-1:0]      dp_a,
  output logic [W-1:0]      dp_b,
  output logic              dp_mode,
  input  logic [W-1:0]      dp_sum,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [W-1:0]      rsp_sum,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;

  state_t         state_q;
  logic [W-1:0]   op_a_q;
  logic [W-1:0]   op_b_q;
  logic           op_mode_q;
  logic [IDW-1:0] id_q;
  logic [W-1:0]   sum_q;
  logic           rsp_valid_q;
  logic           busy_q;

  logic           gnt_found;
  logic [IDW-1:0] gnt_idx;
  logic [IDW-1:0] sel;

`ifdef ADDSUB_ARB_RR_EN
  logic [IDW-1:0] ptr_q;
  int             slot;

  // Round-robin search: scan from ptr_q+NREQ down to ptr_q+1 so the slot right after the pointer wins.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    sel       = '0;
    slot      = 0;
    for (int k = NREQ; k >= 1; k--) begin
      slot = (int'(ptr_q) + k) % NREQ;
      sel  = IDW'(slot);
      if (req_valid[sel]) begin
        gnt_found = 1'b1;
        gnt_idx   = sel;
      end
    end
  end
`else
  // Fixed priority: scan from the top so the lowest asserted index is the last one written.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    sel       = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      sel = IDW'(k);
      if (req_valid[sel]) begin
        gnt_found = 1'b1;
        gnt_idx   = sel;
      end
    end
  end
`endif

  // Grant strobe is combinational in IDLE only; gated by rstN so it is silent while reset is held.
  always_comb begin
    req_ready = '0;
    if (rstN && (state_q == IDLE) && gnt_found) begin
      req_ready[gnt_idx] = 1'b1;
    end
  end

  // Operation FSM: latch the winner, let the datapath register its result, capture it, hold until consumed.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q     <= IDLE;
      op_a_q      <= '0;
      op_b_q      <= '0;
      op_mode_q   <= 1'b0;
      id_q        <= '0;
      sum_q       <= '0;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef ADDSUB_ARB_RR_EN
      ptr_q       <= IDW'(NREQ - 1);
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (gnt_found) begin
            op_a_q    <= req_a[int'(gnt_idx)*W +: W];
            op_b_q    <= req_b[int'(gnt_idx)*W +: W];
            op_mode_q <= req_mode[gnt_idx];
            id_q      <= gnt_idx;
            busy_q    <= 1'b1;
            state_q   <= ISSUE;
`ifdef ADDSUB_ARB_RR_EN
            ptr_q     <= gnt_idx;
`endif
          end
        end
        ISSUE: begin
          state_q <= CAPTURE;
        end
        CAPTURE: begin
          sum_q       <= dp_sum;
          rsp_valid_q <= 1'b1;
          state_q     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign dp_a      = op_a_q;
  assign dp_b      = op_b_q;
  assign dp_mode   = op_mode_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = id_q;
  assign rsp_sum   = sum_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_addsub_arbiter.sv
// tb/tb_addsub_arbiter.sv - directed self-checking bench for addsub_arbiter
module tb_addsub_arbiter;
  localparam int NREQ = 4;
  localparam int W    = 32;

  logic              clk = 1'b0;
  logic              rstN;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_mode;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic [NREQ-1:0]   req_ready;
  logic [W-1:0]      dp_a;
  logic [W-1:0]      dp_b;
  logic              dp_mode;
  logic [W-1:0]      dp_sum = '0;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [1:0]        rsp_id;
  logic [W-1:0]      rsp_sum;
  logic              busy;

  int total = 0;
  int bad   = 0;

  addsub_arbiter #(.NREQ(NREQ), .W(W)) dut (
    .clk(clk), .rstN(rstN),
    .req_valid(req_valid), .req_mode(req_mode), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready),
    .dp_a(dp_a), .dp_b(dp_b), .dp_mode(dp_mode), .dp_sum(dp_sum),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_sum(rsp_sum),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // external registered add/sub datapath
  always @(posedge clk) dp_sum <= dp_mode ? (dp_a - dp_b) : (dp_a + dp_b);

  typedef struct {
    int         idx;
    logic [31:0] a;
    logic [31:0] b;
    logic        mode;
    logic [31:0] sum;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int idx, input logic [31:0] a, input logic [31:0] b, input logic mode);
    req_a[idx*W +: W] = a;
    req_b[idx*W +: W] = b;
    req_mode[idx]     = mode;
    req_valid[idx]    = 1'b1;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_req_ready"}, 64'(req_ready), 64'd0);
    chk({tag, "_dp_a"}, 64'(dp_a), 64'd0);
    chk({tag, "_dp_b"}, 64'(dp_b), 64'd0);
    chk({tag, "_dp_mode"}, 64'(dp_mode), 64'd0);
    chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
    chk({tag, "_rsp_id"}, 64'(rsp_id), 64'd0);
    chk({tag, "_rsp_sum"}, 64'(rsp_sum), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
  endtask

  task automatic do_reset();
    rstN = 1'b0;
    tick();
    tick();
    rstN = 1'b1;
  endtask

  int gnt_seen[5];
  int gnt_cyc[5];
  int ngnt;
  int cyc;
  int viol;
  int waited;
  logic [31:0] held_sum;
  logic [1:0]  held_id;

  initial begin
    vecs[0] = '{2, 32'd7,          32'd5,          1'b0, 32'd12};
    vecs[1] = '{0, 32'd0,          32'd1,          1'b1, 32'hFFFF_FFFF};
    vecs[2] = '{1, 32'hFFFF_FFFF,  32'd1,          1'b0, 32'd0};
    vecs[3] = '{3, 32'd100,        32'd30,         1'b1, 32'd70};
    vecs[4] = '{0, 32'h8000_0000,  32'h8000_0000,  1'b0, 32'd0};
    vecs[5] = '{1, 32'd5,          32'd7,          1'b1, 32'hFFFF_FFFE};

    rstN      = 1'b0;
    req_valid = '0;
    req_mode  = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;
    #3;
    check_zero("reset");
    tick();
    tick();
    rstN = 1'b1;

    // table-driven single operations with exact latency
    for (int v = 0; v < 6; v++) begin
      set_req(vecs[v].idx, vecs[v].a, vecs[v].b, vecs[v].mode);
      @(negedge clk);
      chk($sformatf("v%0d_req_ready", v), 64'(req_ready), 64'(4'b0001 << vecs[v].idx));
      tick();
      req_valid = '0;
      @(negedge clk);
      chk($sformatf("v%0d_issue_ready0", v), 64'(req_ready), 64'd0);
      chk($sformatf("v%0d_issue_busy", v), 64'(busy), 64'd1);
      chk($sformatf("v%0d_issue_valid0", v), 64'(rsp_valid), 64'd0);
      chk($sformatf("v%0d_dp_a", v), 64'(dp_a), 64'(vecs[v].a));
      chk($sformatf("v%0d_dp_b", v), 64'(dp_b), 64'(vecs[v].b));
      chk($sformatf("v%0d_dp_mode", v), 64'(dp_mode), 64'(vecs[v].mode));
      tick();
      @(negedge clk);
      chk($sformatf("v%0d_capture_valid0", v), 64'(rsp_valid), 64'd0);
      chk($sformatf("v%0d_capture_dp_a", v), 64'(dp_a), 64'(vecs[v].a));
      tick();
      @(negedge clk);
      chk($sformatf("v%0d_rsp_valid", v), 64'(rsp_valid), 64'd1);
      chk($sformatf("v%0d_rsp_sum", v), 64'(rsp_sum), 64'(vecs[v].sum));
      chk($sformatf("v%0d_rsp_id", v), 64'(rsp_id), 64'(vecs[v].idx));
      tick();
      @(negedge clk);
      chk($sformatf("v%0d_idle_busy", v), 64'(busy), 64'd0);
      chk($sformatf("v%0d_idle_valid", v), 64'(rsp_valid), 64'd0);
      tick();
    end

    // arbitration order with all requesters continuously valid
    do_reset();
    for (int i = 0; i < NREQ; i++) set_req(i, 32'(i * 10), 32'd1, 1'b0);
    rsp_ready = 1'b1;
    ngnt = 0;
    for (cyc = 0; cyc < 40 && ngnt < 5; cyc++) begin
      @(negedge clk);
      if (req_ready != '0) begin
        for (int i = 0; i < NREQ; i++) if (req_ready[i]) gnt_seen[ngnt] = i;
        gnt_cyc[ngnt] = cyc;
        ngnt++;
      end
      tick();
    end
    chk("arb_grant_count", 64'(ngnt), 64'd5);
    for (int g = 0; g < ngnt; g++) begin
`ifdef ADDSUB_ARB_RR_EN
      chk($sformatf("arb_grant%0d", g), 64'(gnt_seen[g]), 64'(g % NREQ));
`else
      chk($sformatf("arb_grant%0d", g), 64'(gnt_seen[g]), 64'd0);
`endif
      if (g > 0) chk($sformatf("arb_spacing%0d", g), 64'(gnt_cyc[g] - gnt_cyc[g-1]), 64'd4);
    end
    req_valid = '0;
    waited = 0;
    while (busy && waited < 20) begin tick(); waited++; end
    chk("arb_drain", 64'(busy), 64'd0);

    // backpressure: hold response 10 cycles, then grant on the cycle after rsp_ready rises
    rsp_ready = 1'b0;
    set_req(3, 32'd1000, 32'd1, 1'b1);
    tick();
    req_valid = '0;
    waited = 0;
    while (!rsp_valid && waited < 20) begin tick(); waited++; end
    chk("bp_rsp_arrives", 64'(rsp_valid), 64'd1);
    held_sum = rsp_sum;
    held_id  = rsp_id;
    chk("bp_sum", 64'(held_sum), 64'd999);
    chk("bp_id", 64'(held_id), 64'd3);
    set_req(0, 32'd2, 32'd3, 1'b0);
    viol = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b1 || rsp_sum !== held_sum || rsp_id !== held_id || req_ready !== '0) viol++;
      tick();
    end
    chk("bp_stable_10", 64'(viol), 64'd0);
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_no_grant_same_cycle", 64'(req_ready), 64'd0);
    tick();
    @(negedge clk);
    chk("bp_next_grant", 64'(req_ready), 64'b0001);
    tick();
    req_valid = '0;
    waited = 0;
    while (busy && waited < 20) begin tick(); waited++; end
    chk("bp_drain", 64'(busy), 64'd0);

    // asynchronous reset while in CAPTURE
    do_reset();
    for (int i = 0; i < NREQ; i++) set_req(i, 32'(i + 5), 32'd2, 1'b0);
    @(negedge clk);
    chk("rst_pre_grant", 64'(req_ready), 64'b0001);
    tick();
    req_valid = '0;
    tick();
    #2;
    rstN = 1'b0;
    #1;
    check_zero("rst_capture");
    tick();
    tick();
    rstN = 1'b1;
    viol = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0 || busy !== 1'b0) viol++;
      tick();
    end
    chk("rst_no_response", 64'(viol), 64'd0);
    for (int i = 0; i < NREQ; i++) set_req(i, 32'(i + 5), 32'd2, 1'b0);
    @(negedge clk);
    chk("rst_first_grant", 64'(req_ready), 64'b0001);
    tick();
    req_valid = '0;
    waited = 0;
    while (busy && waited < 20) begin tick(); waited++; end
    chk("rst_drain", 64'(busy), 64'd0);

    // withdrawal: requester 1 pulses only while the block is busy
    set_req(0, 32'd40, 32'd2, 1'b0);
    tick();
    req_valid = '0;
    req_valid[1] = 1'b1;
    tick();
    req_valid = '0;
    viol = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (req_ready !== '0) viol++;
      if (rsp_valid && rsp_id == 2'd1) viol++;
      if (rsp_valid) begin
        chk("wd_rsp_id", 64'(rsp_id), 64'd0);
        chk("wd_rsp_sum", 64'(rsp_sum), 64'd42);
      end
      tick();
    end
    chk("wd_no_grant_req1", 64'(viol), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
